// File: rtl/cdc_sync_event.sv
// Multi-channel asynchronous level synchronizer with optional debounce filter,
// edge pulses, sticky event flags and masked interrupt. Filter enabled by CDC_SYNC_EVENT_DEBOUNCE_EN.
module cdc_sync_event #(
    parameter int   CHANNELS    = 4,
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic INIT_VAL    = 1'b0,
    parameter int   EVENT_MODE  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] sticky_clr,
    input  logic [CHANNELS-1:0] irq_mask,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] event_sticky,
    output logic                irq
);

    if (CHANNELS < 32'sd1) begin : g_err_channels
        $error("cdc_sync_event: CHANNELS must be >= 1");
    end
    if (STAGES < 32'sd2) begin : g_err_stages
        $error("cdc_sync_event: STAGES must be >= 2");
    end
    if (FILT_CYCLES < 32'sd1) begin : g_err_filt
        $error("cdc_sync_event: FILT_CYCLES must be >= 1");
    end
    if ((EVENT_MODE < 32'sd0) || (EVENT_MODE > 32'sd2)) begin : g_err_mode
        $error("cdc_sync_event: EVENT_MODE must be 0, 1 or 2");
    end

    logic [CHANNELS-1:0] sync_raw_s;
    logic [CHANNELS-1:0] filt_s;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] sticky_q;
    logic [CHANNELS-1:0] sticky_d;
    logic [CHANNELS-1:0] evt_s;
    logic                irq_q;
    logic                irq_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
        logic [STAGES-1:0] chain_q;
        logic              filt_q;
        logic              filt_d;

        // Synchronizer chain: stage 0 samples the raw asynchronous input.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= {STAGES{INIT_VAL}};
            end else begin
                chain_q <= {chain_q[STAGES-2:0], async_in[i]};
            end
        end

        assign sync_raw_s[i] = chain_q[STAGES-1];

`ifdef CDC_SYNC_EVENT_DEBOUNCE_EN
        localparam int CW = $clog2(FILT_CYCLES + 1);
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Accept a new level only after it persists FILT_CYCLES cycles; any return restarts the count.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (sync_raw_s[i] == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FILT_CYCLES - 1)) begin
                filt_d = sync_raw_s[i];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Debounce counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
`else
        // Without debounce the filtered level simply follows the synchronizer one cycle later.
        always_comb begin
            filt_d = sync_raw_s[i];
        end
`endif

        // Filtered level register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_q <= INIT_VAL;
            end else begin
                filt_q <= filt_d;
            end
        end

        assign filt_s[i] = filt_q;
    end

    assign sync_out   = filt_s;
    assign rise_pulse = filt_s & ~prev_q;
    assign fall_pulse = ~filt_s & prev_q;

    // Select which edges latch the sticky flag; a set outranks a coincident clear.
    always_comb begin
        case (EVENT_MODE)
            32'sd0:  evt_s = rise_pulse;
            32'sd1:  evt_s = fall_pulse;
            32'sd2:  evt_s = rise_pulse | fall_pulse;
            default: evt_s = '0;
        endcase
        sticky_d = (sticky_q & ~sticky_clr) | evt_s;
        irq_d    = |(sticky_q & irq_mask);
    end

    // History, sticky flags and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= {CHANNELS{INIT_VAL}};
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= filt_s;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    assign event_sticky = sticky_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_cdc_sync_event.sv
// Directed bench for cdc_sync_event (CHANNELS=4, STAGES=2, FILT_CYCLES=4); follows CDC_SYNC_EVENT_DEBOUNCE_EN.
module tb_cdc_sync_event;

`ifdef CDC_SYNC_EVENT_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] async_in, sticky_clr, irq_mask;
    logic [3:0] sync_out, rise_pulse, fall_pulse, event_sticky;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    cdc_sync_event #(
        .CHANNELS(4), .STAGES(2), .FILT_CYCLES(4), .INIT_VAL(1'b0), .EVENT_MODE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .sticky_clr(sticky_clr),
        .irq_mask(irq_mask), .sync_out(sync_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .event_sticky(event_sticky), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ain;
        logic [3:0] clr;
        logic [3:0] mask;
        int         cyc;
        logic [3:0] e_sync;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic [3:0] e_sticky;
        logic       e_irq;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] st, input logic q);
        chk({tag, ".sync_out"}, sync_out, s);
        chk({tag, ".rise_pulse"}, rise_pulse, r);
        chk({tag, ".fall_pulse"}, fall_pulse, f);
        chk({tag, ".event_sticky"}, event_sticky, st);
        chk({tag, ".irq"}, {3'b000, irq}, {3'b000, q});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] ain);
        async_in   = ain;
        sticky_clr = 4'h0;
        irq_mask   = 4'h0;
        rst_n      = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        async_in   = 4'hF;
        sticky_clr = 4'h0;
        irq_mask   = 4'h0;

        // Reset with all inputs high, then all channels rise together.
        tick(3);
        chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;
        tick(LAT - 1);
        chk("rst_rel_early.sync_out", sync_out, 4'h0);
        tick(1);
        chk_all("rst_rel_edge", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        tick(1);
        chk_all("rst_rel_next", 4'hF, 4'h0, 4'h0, 4'hF, 1'b0);

        // Main table from a clean all-zero state.
        tbl[0]  = '{4'h1, 4'h0, 4'h1, LAT - 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{4'h1, 4'h0, 4'h1, 1,       4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{4'h1, 4'h0, 4'h1, 1,       4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
        tbl[3]  = '{4'h1, 4'h0, 4'h1, 1,       4'h1, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[4]  = '{4'h0, 4'h0, 4'h1, LAT - 1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[5]  = '{4'h0, 4'h0, 4'h1, 1,       4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
        tbl[6]  = '{4'h0, 4'h1, 4'h1, 1,       4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[7]  = '{4'h0, 4'h1, 4'h1, 1,       4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[8]  = '{4'h0, 4'h0, 4'h1, 1,       4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{4'h2, 4'h0, 4'h0, LAT + 1, 4'h2, 4'h0, 4'h0, 4'h2, 1'b0};
        tbl[10] = '{4'h2, 4'h0, 4'h2, 1,       4'h2, 4'h0, 4'h0, 4'h2, 1'b1};

        do_reset(4'h0);
        for (int i = 0; i < 11; i++) begin
            async_in   = tbl[i].ain;
            sticky_clr = tbl[i].clr;
            irq_mask   = tbl[i].mask;
            tick(tbl[i].cyc);
            chk_all($sformatf("vec%0d", i), tbl[i].e_sync, tbl[i].e_rise,
                    tbl[i].e_fall, tbl[i].e_sticky, tbl[i].e_irq);
        end
        sticky_clr = 4'h0;

`ifdef CDC_SYNC_EVENT_DEBOUNCE_EN
        // Three-cycle excursion on ch1 is rejected.
        do_reset(4'h0);
        for (int e = 1; e <= 12; e++) begin
            async_in = (e <= 3) ? 4'h2 : 4'h0;
            tick(1);
            chk($sformatf("glitch3_e%0d.sync_out", e), sync_out, 4'h0);
            chk($sformatf("glitch3_e%0d.pulses", e), rise_pulse | fall_pulse, 4'h0);
        end
        chk("glitch3.event_sticky", event_sticky, 4'h0);

        // Four-cycle excursion on ch1 is just long enough to pass.
        do_reset(4'h0);
        for (int e = 1; e <= 12; e++) begin
            async_in = (e <= 4) ? 4'h2 : 4'h0;
            tick(1);
            chk($sformatf("pulse4_e%0d.sync_out", e), sync_out,
                (e >= 6 && e <= 9) ? 4'h2 : 4'h0);
            chk($sformatf("pulse4_e%0d.rise", e), rise_pulse, (e == 6) ? 4'h2 : 4'h0);
            chk($sformatf("pulse4_e%0d.fall", e), fall_pulse, (e == 10) ? 4'h2 : 4'h0);
        end
`else
        // Single-cycle glitch on ch3 passes straight through as rise then fall.
        do_reset(4'h0);
        for (int e = 1; e <= 8; e++) begin
            async_in = (e == 1) ? 4'h8 : 4'h0;
            tick(1);
            chk($sformatf("glitch1_e%0d.sync_out", e), sync_out, (e == 3) ? 4'h8 : 4'h0);
            chk($sformatf("glitch1_e%0d.rise", e), rise_pulse, (e == 3) ? 4'h8 : 4'h0);
            chk($sformatf("glitch1_e%0d.fall", e), fall_pulse, (e == 4) ? 4'h8 : 4'h0);
        end
        chk("glitch1.event_sticky", event_sticky, 4'h8);
`endif

        // Reset mid-filter on ch2 discards progress; full latency needed afterwards.
        do_reset(4'h0);
        async_in = 4'h4;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk_all("midrst_async", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(LAT - 1);
        chk("midrst_early.sync_out", sync_out, 4'h0);
        tick(1);
        chk("midrst_edge.sync_out", sync_out, 4'h4);
        chk("midrst_edge.rise", rise_pulse, 4'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
